mau_load_store: RTL and testbench

Memory access unit for the RV32I core. Accepts one load/store at a time from the execute stage, runs a req/ack transaction on the data bus, and returns load results to the register file's MAU write port (`rdmau`/`rdmau_en`/`data_mau_in`). Exports the pending load destination so the issue stage can stall on RAW hazards and avoid same-register collisions, where the register file's writeback port wins.

---
 rtl/mau_pkg.sv | 33 +++
 rtl/mau_load_store_if.sv | 42 ++++
 rtl/mau_align.sv | 70 +++++++
 rtl/mau_load_store.sv | 192 +++++++++++++++++++
 tb/tb_mau_load_store.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: funct3 codes, FSM states,
// exception cause codes and the funct3 legality helper.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_MISALIGN = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WB   = 2'd2
  } state_e;

  // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) begin
      bad = (f3 > F3_W);
    end else begin
      bad = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU));
    end
    return bad;
  endfunction

endpackage

// File: rtl/mau_load_store_if.sv
// Execute-stage request, data bus, writeback and exception signals of the MAU.
interface mau_load_store_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [4:0]  rdmau;
  logic        rdmau_en;
  logic [31:0] data_mau_in;
  logic        busy_valid;
  logic [4:0]  busy_rd;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
           mem_ack, mem_rdata, mem_err,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rdmau, rdmau_en, data_mau_in, busy_valid, busy_rd,
           err_valid, err_cause, err_addr
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
           mem_ack, mem_rdata, mem_err,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rdmau, rdmau_en, data_mau_in, busy_valid, busy_rd,
           err_valid, err_cause, err_addr
  );
endinterface

// File: rtl/mau_align.sv
// Combinational lane logic: store replication / byte enables, load
// extraction / extension, and request legality checks.
module mau_align
  import mau_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misalign,
  output logic        o_illegal
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: size comes from funct3[1:0], lanes shifted by the byte offset.
  always_comb begin
    o_be    = 4'hF;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'd0: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'd1: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    w_byte  = 8'd0;
    w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_ldata = i_rdata;
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ldata = {24'd0, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ldata = {16'd0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

  // Legality: halfwords need even addresses, words need 4-byte alignment.
  always_comb begin
    o_illegal  = f3_illegal(i_we, i_funct3);
    o_misalign = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: o_misalign = i_off[0];
      F3_W:        o_misalign = (i_off != 2'd0);
      default:     o_misalign = 1'b0;
    endcase
  end
endmodule

// File: rtl/mau_load_store.sv
// Memory access unit: one load/store at a time over a req/ack bus, load
// results to the register file MAU port, pending-load hazard export.
module mau_load_store
  import mau_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mau_load_store_if.slave bus
);
  state_e      r_state, w_state_d;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [4:0]  r_rd;
  logic        r_req_ready, r_mem_req, r_mem_we, r_rdmau_en;
  logic        r_busy_valid, r_err_valid;
  logic [31:0] r_mem_addr, r_mem_wdata, r_data, r_err_addr;
  logic [3:0]  r_mem_be;
  logic [4:0]  r_rdmau, r_busy_rd;
  logic [1:0]  r_err_cause;

  logic        w_we_d, w_req_ready_d, w_mem_req_d, w_mem_we_d, w_rdmau_en_d;
  logic        w_busy_valid_d, w_err_valid_d;
  logic [2:0]  w_funct3_d;
  logic [31:0] w_addr_d, w_mem_addr_d, w_mem_wdata_d, w_data_d, w_err_addr_d;
  logic [4:0]  w_rd_d, w_rdmau_d, w_busy_rd_d;
  logic [3:0]  w_mem_be_d;
  logic [1:0]  w_err_cause_d;

  logic        w_accept, w_idle, w_misalign, w_illegal;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_st_data, w_ld_data;

  // While idle the lane logic looks at the incoming request; afterwards it
  // formats the read data of the registered request.
  assign w_idle   = (r_state == IDLE);
  assign w_accept = bus.req_valid && r_req_ready;
  assign w_f3     = w_idle ? bus.req_funct3 : r_funct3;
  assign w_off    = w_idle ? bus.req_addr[1:0] : r_addr[1:0];

  mau_align u_align (
    .i_we       (bus.req_we),
    .i_funct3   (w_f3),
    .i_off      (w_off),
    .i_wdata    (bus.req_wdata),
    .i_rdata    (bus.mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_st_data),
    .o_ldata    (w_ld_data),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // Next-state and next-output logic; everything holds unless a transition acts.
  always_comb begin
    w_state_d      = r_state;
    w_we_d         = r_we;
    w_funct3_d     = r_funct3;
    w_addr_d       = r_addr;
    w_rd_d         = r_rd;
    w_mem_req_d    = r_mem_req;
    w_mem_we_d     = r_mem_we;
    w_mem_addr_d   = r_mem_addr;
    w_mem_be_d     = r_mem_be;
    w_mem_wdata_d  = r_mem_wdata;
    w_rdmau_d      = r_rdmau;
    w_rdmau_en_d   = 1'b0;
    w_data_d       = r_data;
    w_busy_valid_d = r_busy_valid;
    w_busy_rd_d    = r_busy_rd;
    w_err_valid_d  = 1'b0;
    w_err_cause_d  = r_err_cause;
    w_err_addr_d   = r_err_addr;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_we_d     = bus.req_we;
          w_funct3_d = bus.req_funct3;
          w_addr_d   = bus.req_addr;
          w_rd_d     = bus.req_rd;
          if (w_illegal || w_misalign) begin
            w_err_valid_d = 1'b1;
            w_err_cause_d = w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
            w_err_addr_d  = bus.req_addr;
          end else begin
            w_state_d      = BUS;
            w_mem_req_d    = 1'b1;
            w_mem_we_d     = bus.req_we;
            w_mem_addr_d   = {bus.req_addr[31:2], 2'b00};
            w_mem_be_d     = w_be;
            w_mem_wdata_d  = w_st_data;
            w_busy_valid_d = !bus.req_we && (bus.req_rd != 5'd0);
            w_busy_rd_d    = bus.req_we ? 5'd0 : bus.req_rd;
          end
        end else begin
          w_state_d = IDLE;
        end
      end
      BUS: begin
        if (bus.mem_ack) begin
          w_mem_req_d    = 1'b0;
          w_busy_valid_d = 1'b0;
          w_busy_rd_d    = 5'd0;
          if (bus.mem_err) begin
            w_state_d     = IDLE;
            w_err_valid_d = 1'b1;
            w_err_cause_d = ERR_BUS;
            w_err_addr_d  = r_addr;
          end else if (r_we) begin
            w_state_d = IDLE;
          end else begin
            w_state_d    = WB;
            w_data_d     = w_ld_data;
            w_rdmau_d    = r_rd;
            w_rdmau_en_d = (r_rd != 5'd0);
          end
        end else begin
          w_state_d = BUS;
        end
      end
      WB:      w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    w_req_ready_d = (w_state_d == IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // Request capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 32'd0;
      r_rd         <= 5'd0;
      r_req_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_be     <= 4'd0;
      r_mem_wdata  <= 32'd0;
      r_rdmau      <= 5'd0;
      r_rdmau_en   <= 1'b0;
      r_data       <= 32'd0;
      r_busy_valid <= 1'b0;
      r_busy_rd    <= 5'd0;
      r_err_valid  <= 1'b0;
      r_err_cause  <= 2'd0;
      r_err_addr   <= 32'd0;
    end else begin
      r_we         <= w_we_d;
      r_funct3     <= w_funct3_d;
      r_addr       <= w_addr_d;
      r_rd         <= w_rd_d;
      r_req_ready  <= w_req_ready_d;
      r_mem_req    <= w_mem_req_d;
      r_mem_we     <= w_mem_we_d;
      r_mem_addr   <= w_mem_addr_d;
      r_mem_be     <= w_mem_be_d;
      r_mem_wdata  <= w_mem_wdata_d;
      r_rdmau      <= w_rdmau_d;
      r_rdmau_en   <= w_rdmau_en_d;
      r_data       <= w_data_d;
      r_busy_valid <= w_busy_valid_d;
      r_busy_rd    <= w_busy_rd_d;
      r_err_valid  <= w_err_valid_d;
      r_err_cause  <= w_err_cause_d;
      r_err_addr   <= w_err_addr_d;
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_be      = r_mem_be;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.rdmau       = r_rdmau;
  assign bus.rdmau_en    = r_rdmau_en;
  assign bus.data_mau_in = r_data;
  assign bus.busy_valid  = r_busy_valid;
  assign bus.busy_rd     = r_busy_rd;
  assign bus.err_valid   = r_err_valid;
  assign bus.err_cause   = r_err_cause;
  assign bus.err_addr    = r_err_addr;
endmodule

// File: tb/tb_mau_load_store.sv
// Self-checking bench for mau_load_store: directed cases then random
// transactions against an arithmetic reference model.
module tb_mau_load_store;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mau_load_store_if bus ();

  mau_load_store dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // -1: no exception, else the expected cause code.
  function automatic int model_cause(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1;
    size = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    if ((addr % size) != 0) return 0;
    return -1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
      3'd5: v = v & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] wo);
    if (f3 == 3'd0) begin
      be = 4'(1 << (addr % 4));
      wo = (wd & 32'hFF) * 32'h01010101;
    end else if (f3 == 3'd1) begin
      be = 4'(3 << (addr % 4));
      wo = (wd & 32'hFFFF) * 32'h00010001;
    end else begin
      be = 4'hF;
      wo = wd;
    end
  endtask

  // Runs one request from offer to completion, checking every cycle.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int k,
                       input logic [31:0] rdata, input logic err);
    int          cause;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld;
    bit          wb;
    cause = model_cause(we, f3, addr);
    model_store(f3, addr, wd, ebe, ewd);
    eld = model_load(f3, addr, rdata);
    wb  = !we && (rd != 5'd0);
    chk("ready_idle", bus.req_ready, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_rd = rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (cause >= 0) begin
      chk("err_valid", bus.err_valid, 32'd1);
      chk("err_cause", bus.err_cause, 32'(cause));
      chk("err_addr", bus.err_addr, addr);
      chk("no_mem_req", bus.mem_req, 32'd0);
      chk("no_busy", bus.busy_valid, 32'd0);
      @(negedge clk);
      chk("err_pulse_end", bus.err_valid, 32'd0);
      chk("no_mem_req2", bus.mem_req, 32'd0);
      return;
    end
    chk("mem_we", bus.mem_we, 32'(we));
    chk("busy_valid", bus.busy_valid, 32'(wb));
    chk("busy_rd", bus.busy_rd, wb ? 32'(rd) : 32'd0);
    for (int c = 1; c <= k; c++) begin
      chk("mem_req", bus.mem_req, 32'd1);
      chk("mem_addr", bus.mem_addr, addr & 32'hFFFFFFFC);
      if (we) begin
        chk("mem_be", bus.mem_be, 32'(ebe));
        chk("mem_wdata", bus.mem_wdata, ewd);
      end
      if (c == k) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = rdata; bus.mem_err = err;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = $urandom;
    chk("req_drop", bus.mem_req, 32'd0);
    chk("busy_clear", bus.busy_valid, 32'd0);
    if (err) begin
      chk("bus_err_valid", bus.err_valid, 32'd1);
      chk("bus_err_cause", bus.err_cause, 32'd2);
      chk("bus_err_addr", bus.err_addr, addr);
      chk("bus_err_no_wb", bus.rdmau_en, 32'd0);
      chk("bus_err_ready", bus.req_ready, 32'd1);
    end else if (we) begin
      chk("st_no_wb", bus.rdmau_en, 32'd0);
      chk("st_ready", bus.req_ready, 32'd1);
      chk("st_no_err", bus.err_valid, 32'd0);
    end else begin
      chk("rdmau_en", bus.rdmau_en, 32'(wb));
      if (wb) begin
        chk("rdmau", bus.rdmau, 32'(rd));
        chk("data_mau_in", bus.data_mau_in, eld);
      end
      chk("wb_not_ready", bus.req_ready, 32'd0);
      @(negedge clk);
      chk("wb_ready", bus.req_ready, 32'd1);
      chk("wb_pulse_end", bus.rdmau_en, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0; bus.mem_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.req_ready, 32'd1);
    chk("rst_mem_req", bus.mem_req, 32'd0);
    chk("rst_rdmau_en", bus.rdmau_en, 32'd0);
    chk("rst_busy", bus.busy_valid, 32'd0);
    chk("rst_err", bus.err_valid, 32'd0);
    chk("rst_data", bus.data_mau_in, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(1'b0, 3'd2, 32'h100, 32'd0, 5'd5, 1, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 3'd0, 32'h103, 32'd0, 5'd6, 1, 32'h80FF1234, 1'b0);
    do_op(1'b0, 3'd4, 32'h103, 32'd0, 5'd7, 2, 32'h80FF1234, 1'b0);
    do_op(1'b0, 3'd1, 32'h102, 32'd0, 5'd8, 1, 32'h80FF1234, 1'b0);
    do_op(1'b1, 3'd0, 32'h201, 32'h000000AB, 5'd3, 1, 32'd0, 1'b0);
    do_op(1'b1, 3'd1, 32'h202, 32'h1234CDEF, 5'd0, 3, 32'd0, 1'b0);
    do_op(1'b0, 3'd2, 32'h102, 32'd0, 5'd9, 1, 32'd0, 1'b0);
    do_op(1'b0, 3'd3, 32'h100, 32'd0, 5'd9, 1, 32'd0, 1'b0);
    do_op(1'b1, 3'd5, 32'h100, 32'd0, 5'd9, 1, 32'd0, 1'b0);
    do_op(1'b0, 3'd2, 32'h140, 32'd0, 5'd10, 4, 32'h55AA55AA, 1'b1);
    do_op(1'b0, 3'd2, 32'h144, 32'd0, 5'd0, 2, 32'h12345678, 1'b0);

    // Stray ack while idle must do nothing.
    bus.mem_ack = 1'b1; bus.mem_err = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
    chk("stray_ack_err", bus.err_valid, 32'd0);
    chk("stray_ack_wb", bus.rdmau_en, 32'd0);
    chk("stray_ack_ready", bus.req_ready, 32'd1);

    // Reset while the bus transaction is outstanding.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h300; bus.req_rd = 5'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("pre_rst_req", bus.mem_req, 32'd1);
    chk("pre_rst_busy", bus.busy_valid, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_req", bus.mem_req, 32'd0);
    chk("async_rst_busy", bus.busy_valid, 32'd0);
    chk("async_rst_ready", bus.req_ready, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_op(1'b0, 3'd2, 32'h300, 32'd0, 5'd7, 1, 32'hCAFEF00D, 1'b0);

    // Random transactions.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            5'($urandom_range(0, 31)), int'($urandom_range(1, 4)), $urandom,
            1'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
